// File: rtl/calc_operand_sequencer_pkg.sv
// Shared constants for the calculator front end: FSM state codes, ALU opcodes
// and the opcode saturation helper used when the operation is captured.
package calc_operand_sequencer_pkg;

  typedef logic [2:0] state_t;
  typedef logic [3:0] opcode_t;

  localparam state_t ST_LOAD_A  = 3'd0;
  localparam state_t ST_LOAD_B  = 3'd1;
  localparam state_t ST_LOAD_OP = 3'd2;
  localparam state_t ST_EXEC    = 3'd3;
  localparam state_t ST_SHOW    = 3'd4;

  localparam opcode_t OP_ADD = 4'd0;
  localparam opcode_t OP_SUB = 4'd1;
  localparam opcode_t OP_MUL = 4'd2;
  localparam opcode_t OP_AND = 4'd3;
  localparam opcode_t OP_OR  = 4'd4;
  localparam opcode_t OP_XOR = 4'd5;
  localparam opcode_t OP_NOT = 4'd6;
  localparam opcode_t OP_INC = 4'd7;
  localparam opcode_t OP_SHL = 4'd8;
  localparam opcode_t OP_SHR = 4'd9;
  localparam opcode_t OP_MAX = 4'b1001;

  // Codes above the last defined ALU operation collapse onto it.
  function automatic opcode_t saturate_op(input opcode_t op);
    opcode_t res;
    if (op > OP_MAX) begin
      res = OP_MAX;
    end else begin
      res = op;
    end
    return res;
  endfunction

endpackage

// File: rtl/calc_operand_sequencer_if.sv
// Board-facing and ALU-facing signal bundle of the operand sequencer.
interface calc_operand_sequencer_if #(
  parameter int WL = 6
) ();

  logic [WL-1:0] switches;
  logic [3:0]    op_switches;
  logic          enter;
  logic          clear;
  logic [WL-1:0] alu_c;
  logic          alu_carry;
  logic [WL-1:0] a;
  logic [WL-1:0] b;
  logic [3:0]    control;
  logic [WL-1:0] result;
  logic          result_carry;
  logic          result_valid;
  logic [2:0]    state_code;

  modport master (
    input  switches,
    input  op_switches,
    input  enter,
    input  clear,
    input  alu_c,
    input  alu_carry,
    output a,
    output b,
    output control,
    output result,
    output result_carry,
    output result_valid,
    output state_code
  );

  modport slave (
    output switches,
    output op_switches,
    output enter,
    output clear,
    output alu_c,
    output alu_carry,
    input  a,
    input  b,
    input  control,
    input  result,
    input  result_carry,
    input  result_valid,
    input  state_code
  );

endinterface

// File: rtl/calc_operand_sequencer_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and rising-edge
// detector producing a single one-cycle pulse per accepted press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic          pulse_r;
  logic [CW-1:0] cnt_r;
  logic          accept_s;

  // A changed level is accepted once it has differed for DEBOUNCE_CYCLES samples.
  assign accept_s = (sync2_r != stable_r) && (cnt_r == CNT_LAST);

  // Two-stage synchronizer for the asynchronous button level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter; any return to the accepted level restarts the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r    <= CNT_ZERO;
      stable_r <= 1'b0;
    end else if (sync2_r == stable_r) begin
      cnt_r    <= CNT_ZERO;
    end else if (accept_s) begin
      cnt_r    <= CNT_ZERO;
      stable_r <= sync2_r;
    end else begin
      cnt_r    <= cnt_r + CNT_ONE;
    end
  end

  // Pulse only on acceptance of a press, never on a release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_r <= 1'b0;
    end else begin
      pulse_r <= accept_s & sync2_r;
    end
  end

  assign btn_pulse = pulse_r;

endmodule

// File: rtl/calc_operand_sequencer.sv
// Calculator front end: collects A, B and opcode on Enter presses, drives the
// combinational ALU, waits a settle window and latches its result for display.
module calc_operand_sequencer #(
  parameter int Word_Length     = 6,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  calc_operand_sequencer_if.master  bus
);

  import calc_operand_sequencer_pkg::*;

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_CAPTURE = CNT_W'(SETTLE_CYCLES + 1);
  localparam logic [Word_Length-1:0] WORD_ZERO = {Word_Length{1'b0}};

  logic                   enter_p_s;
  logic                   clear_p_s;
  state_t                 state_r;
  logic [CNT_W-1:0]       exec_cnt_r;
  logic [Word_Length-1:0] shadow_a_r;
  logic [Word_Length-1:0] shadow_b_r;
  opcode_t                shadow_op_r;
  logic [Word_Length-1:0] a_r;
  logic [Word_Length-1:0] b_r;
  opcode_t                control_r;
  logic [Word_Length-1:0] result_r;
  logic                   result_carry_r;
  logic                   result_valid_r;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter_db (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (bus.enter),
    .btn_pulse(enter_p_s)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_db (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (bus.clear),
    .btn_pulse(clear_p_s)
  );

  // Sequencer FSM with shadow capture, EXEC timing and result latch; Clear has priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_LOAD_A;
      exec_cnt_r     <= CNT_ZERO;
      shadow_a_r     <= WORD_ZERO;
      shadow_b_r     <= WORD_ZERO;
      shadow_op_r    <= 4'b0000;
      a_r            <= WORD_ZERO;
      b_r            <= WORD_ZERO;
      control_r      <= 4'b0000;
      result_r       <= WORD_ZERO;
      result_carry_r <= 1'b0;
      result_valid_r <= 1'b0;
    end else if (clear_p_s) begin
      state_r        <= ST_LOAD_A;
      exec_cnt_r     <= CNT_ZERO;
      shadow_a_r     <= WORD_ZERO;
      shadow_b_r     <= WORD_ZERO;
      shadow_op_r    <= 4'b0000;
      result_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_LOAD_A: begin
          if (enter_p_s) begin
            shadow_a_r <= bus.switches;
            state_r    <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (enter_p_s) begin
            shadow_b_r <= bus.switches;
            state_r    <= ST_LOAD_OP;
          end
        end
        ST_LOAD_OP: begin
          if (enter_p_s) begin
            shadow_op_r <= saturate_op(bus.op_switches);
            exec_cnt_r  <= CNT_ZERO;
            state_r     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Opcode goes out first so the ALU sees a stable operation when operands move.
          exec_cnt_r <= exec_cnt_r + CNT_ONE;
          if (exec_cnt_r == CNT_ZERO) begin
            control_r <= shadow_op_r;
          end
          if (exec_cnt_r == CNT_ONE) begin
            a_r <= shadow_a_r;
            b_r <= shadow_b_r;
          end
          if (exec_cnt_r == CNT_CAPTURE) begin
            result_r       <= bus.alu_c;
            result_carry_r <= bus.alu_carry;
            result_valid_r <= 1'b1;
            state_r        <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (enter_p_s) begin
            result_valid_r <= 1'b0;
            state_r        <= ST_LOAD_A;
          end
        end
        default: begin
          result_valid_r <= 1'b0;
          state_r        <= ST_LOAD_A;
        end
      endcase
    end
  end

  assign bus.a            = a_r;
  assign bus.b            = b_r;
  assign bus.control      = control_r;
  assign bus.result       = result_r;
  assign bus.result_carry = result_carry_r;
  assign bus.result_valid = result_valid_r;
  assign bus.state_code   = state_r;

endmodule
